// File: rtl/note_scheduler.sv
// -----------------------------------------------------------------------------
// note_scheduler
//
// Walks a beat chart held in an external synchronous ROM, one chart step at a
// time. It drives the per-lane spawn levels that feed the top of each lane's
// shift register, and the shared scroll_tick that advances every lane. It also
// owns the start, pause and end-of-song sequencing.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        level; begins a song when idle or done, ignored while busy
//   pause        level; freezes playback while high (PLAY/DRAIN only)
//   pat_addr     chart ROM address (registered)
//   pat_data     ROM data, valid one cycle after pat_addr;
//                [NUM_LANES-1:0] lane notes, [NUM_LANES] end-of-chart flag
//   scroll_tick  one-clk pulse enabling lane shift
//   spawn        per-lane spawn level (registered)
//   step_idx     index of the step currently spawning (registered)
//   busy         high in FETCH/WAIT/PLAY/DRAIN (registered)
//   done         high in DONE (registered)
//
// Optional feature macro: NOTE_SCHEDULER_LOOP_EN
//   When defined, reaching an end row or the last chart step loops playback
//   back to step 0 with no gap. DRAIN/DONE are then reached only when row 0
//   is itself an end row.
//
// scroll_tick is a decode of the divider register gated by the live pause
// level. It cannot be registered without either firing one cycle into a
// pause or losing a tick on resume.
// -----------------------------------------------------------------------------
module note_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int TICK_DIV    = 416667,
    parameter int STEP_TICKS  = 10,
    parameter int BLOCK_TICKS = 5,
    parameter int PATTERN_LEN = 64,
    parameter int DRAIN_TICKS = 96,
    localparam int AW = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    output logic [AW-1:0]        pat_addr,
    input  logic [NUM_LANES:0]   pat_data,
    output logic                 scroll_tick,
    output logic [NUM_LANES-1:0] spawn,
    output logic [AW-1:0]        step_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam int DIV_W = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int TIS_W = (STEP_TICKS > 1)  ? $clog2(STEP_TICKS)  : 1;
    localparam int DRN_W = (DRAIN_TICKS > 1) ? $clog2(DRAIN_TICKS) : 1;
    localparam int RW    = NUM_LANES + 1;

    localparam logic [DIV_W-1:0]     DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]     DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(TICK_DIV - 1);
    localparam logic [TIS_W-1:0]     TIS_ZERO   = {TIS_W{1'b0}};
    localparam logic [TIS_W-1:0]     TIS_ONE    = TIS_W'(1);
    localparam logic [TIS_W-1:0]     TIS_LAST   = TIS_W'(STEP_TICKS - 1);
    localparam logic [TIS_W-1:0]     TIS_BLOCK  = TIS_W'(BLOCK_TICKS);
    localparam logic [DRN_W-1:0]     DRN_ZERO   = {DRN_W{1'b0}};
    localparam logic [DRN_W-1:0]     DRN_ONE    = DRN_W'(1);
    localparam logic [DRN_W-1:0]     DRN_LAST   = DRN_W'(DRAIN_TICKS - 1);
    localparam logic [AW-1:0]        ADDR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]        ADDR_ONE   = AW'(1);
    localparam logic [AW-1:0]        IDX_LAST   = AW'(PATTERN_LEN - 1);
    localparam logic [RW-1:0]        ROW_ZERO   = {RW{1'b0}};
    localparam logic [RW-1:0]        END_ROW    = {1'b1, {NUM_LANES{1'b0}}};
    localparam logic [NUM_LANES-1:0] LANE_ZERO  = {NUM_LANES{1'b0}};

    // A chart row marks end of song through its top bit; lane bits are ignored.
    function automatic logic is_end_row(input logic [RW-1:0] row);
        return row[NUM_LANES];
    endfunction

    function automatic logic is_busy_state(input logic [2:0] st);
        logic result;
        case (st)
            ST_FETCH, ST_WAIT, ST_PLAY, ST_DRAIN: result = 1'b1;
            default:                              result = 1'b0;
        endcase
        return result;
    endfunction

    logic [2:0]           state_r,    state_s;
    logic [DIV_W-1:0]     div_r,      div_s;
    logic [TIS_W-1:0]     tis_r,      tis_s;
    logic [DRN_W-1:0]     drain_r,    drain_s;
    logic [RW-1:0]        row_r,      row_s;
    logic [RW-1:0]        next_row_r, next_row_s;
    logic [AW-1:0]        next_idx_r, next_idx_s;
    logic [AW-1:0]        addr_r,     addr_s;
    logic [AW-1:0]        idx_r,      idx_s;
    logic [NUM_LANES-1:0] spawn_r,    spawn_s;
    logic [1:0]           pipe_r,     pipe_s;
    logic                 busy_r,     busy_s;
    logic                 done_r,     done_s;
    logic                 tick_s;

    // Scroll tick: divider terminal count while running and not paused.
    always_comb begin
        if ((state_r == ST_PLAY || state_r == ST_DRAIN) && !pause && (div_r == DIV_LAST)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Next-state and datapath update for the sequencer.
    // pipe_r tracks an in-flight ROM read: bit 0 while the address is being
    // presented, bit 1 in the cycle the ROM data is valid and gets captured.
    // The whole PLAY datapath, including that pipe, freezes under pause; the
    // ROM keeps returning the held address, so the capture is still valid on
    // resume.
    always_comb begin
        state_s    = state_r;
        div_s      = div_r;
        tis_s      = tis_r;
        drain_s    = drain_r;
        row_s      = row_r;
        next_row_s = next_row_r;
        next_idx_s = next_idx_r;
        addr_s     = addr_r;
        idx_s      = idx_r;
        spawn_s    = spawn_r;
        pipe_s     = pipe_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_FETCH;
                    addr_s  = ADDR_ZERO;
                    pipe_s  = 2'b00;
                end else begin
                    state_s = state_r;
                end
            end
            ST_FETCH: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                row_s      = pat_data;
                div_s      = DIV_ZERO;
                tis_s      = TIS_ZERO;
                drain_s    = DRN_ZERO;
                idx_s      = ADDR_ZERO;
                next_idx_s = ADDR_ZERO;
                next_row_s = ROW_ZERO;
                spawn_s    = LANE_ZERO;
                pipe_s     = 2'b00;
                if (is_end_row(pat_data)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (pause) begin
                    state_s = ST_PLAY;
                end else begin
                    // spawn follows the step counter with one cycle of lag
                    spawn_s = row_r[NUM_LANES-1:0] & {NUM_LANES{tis_r < TIS_BLOCK}};
                    pipe_s  = {pipe_r[0], 1'b0};

                    if (pipe_r[1]) begin
`ifdef NOTE_SCHEDULER_LOOP_EN
                        // An end row found past step 0 redirects the prefetch
                        // to row 0 so playback loops without a gap.
                        if (is_end_row(pat_data) && (addr_r != ADDR_ZERO)) begin
                            addr_s     = ADDR_ZERO;
                            next_idx_s = ADDR_ZERO;
                            pipe_s     = 2'b01;
                        end else begin
                            next_row_s = pat_data;
                        end
`else
                        next_row_s = pat_data;
`endif
                    end else begin
                        next_row_s = next_row_r;
                    end

                    if (tick_s) begin
                        div_s = DIV_ZERO;
                        if (tis_r == TIS_LAST) begin
                            tis_s = TIS_ZERO;
                            row_s = next_row_r;
                            idx_s = next_idx_r;
                            if (is_end_row(next_row_r)) begin
                                state_s = ST_DRAIN;
                                drain_s = DRN_ZERO;
                                spawn_s = LANE_ZERO;
                            end else begin
                                state_s = ST_PLAY;
                            end
                        end else begin
                            tis_s = tis_r + TIS_ONE;
                            // Prefetch the following row early in the step.
                            if (tis_r == TIS_ZERO) begin
                                if (idx_r == IDX_LAST) begin
`ifdef NOTE_SCHEDULER_LOOP_EN
                                    addr_s     = ADDR_ZERO;
                                    next_idx_s = ADDR_ZERO;
                                    pipe_s     = 2'b01;
`else
                                    // Chart ceiling: no read, the address never wraps.
                                    next_row_s = END_ROW;
                                    next_idx_s = idx_r;
`endif
                                end else begin
                                    addr_s     = idx_r + ADDR_ONE;
                                    next_idx_s = idx_r + ADDR_ONE;
                                    pipe_s     = 2'b01;
                                end
                            end else begin
                                addr_s = addr_r;
                            end
                        end
                    end else begin
                        div_s = div_r + DIV_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                spawn_s = LANE_ZERO;
                if (tick_s) begin
                    div_s = DIV_ZERO;
                    if (drain_r == DRN_LAST) begin
                        state_s = ST_DONE;
                    end else begin
                        drain_s = drain_r + DRN_ONE;
                    end
                end else if (!pause) begin
                    div_s = div_r + DIV_ONE;
                end else begin
                    div_s = div_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status flags are derived from the next state so that they register
    // together with it.
    always_comb begin
        busy_s = is_busy_state(state_s);
        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            div_r      <= DIV_ZERO;
            tis_r      <= TIS_ZERO;
            drain_r    <= DRN_ZERO;
            row_r      <= ROW_ZERO;
            next_row_r <= ROW_ZERO;
            next_idx_r <= ADDR_ZERO;
            addr_r     <= ADDR_ZERO;
            idx_r      <= ADDR_ZERO;
            spawn_r    <= LANE_ZERO;
            pipe_r     <= 2'b00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            div_r      <= div_s;
            tis_r      <= tis_s;
            drain_r    <= drain_s;
            row_r      <= row_s;
            next_row_r <= next_row_s;
            next_idx_r <= next_idx_s;
            addr_r     <= addr_s;
            idx_r      <= idx_s;
            spawn_r    <= spawn_s;
            pipe_r     <= pipe_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    assign pat_addr    = addr_r;
    assign scroll_tick = tick_s;
    assign spawn       = spawn_r;
    assign step_idx    = idx_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule
